arriskv_decode_queue: RTL and testbench

ARRISKV_DECODE_QUEUE -- requirements
Module: arriskv_decode_queue

---
 rtl/arriskv_decode_queue.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_arriskv_decode_queue.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arriskv_decode_queue.sv
// Decode queue between fetch and issue: each incoming RV instruction is decoded
// once and the decoded fields plus pc are held in a small in-order FIFO.
module arriskv_decode_queue #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int EN_MEXT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [3:0]      id_type_o,
    output logic [5:0]      id_op_o,
    output logic [4:0]      id_rs1_o,
    output logic [4:0]      id_rs2_o,
    output logic [4:0]      id_rd_o,
    output logic [XLEN-1:0] id_imm_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic            id_jump_o,
    output logic            id_load_o,
    output logic            id_store_o,
    output logic            id_illegal_o,
    output logic [15:0]     illegal_cnt_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [3:0] T_R  = 4'd0;
    localparam logic [3:0] T_I  = 4'd1;
    localparam logic [3:0] T_S  = 4'd2;
    localparam logic [3:0] T_B  = 4'd3;
    localparam logic [3:0] T_U  = 4'd4;
    localparam logic [3:0] T_J  = 4'd5;
    localparam logic [3:0] T_IJ = 4'd6;
    localparam logic [3:0] T_IL = 4'd7;

    localparam logic [5:0] OP_ADDI  = 6'd0;
    localparam logic [5:0] OP_SLTI  = 6'd1;
    localparam logic [5:0] OP_SLTIU = 6'd2;
    localparam logic [5:0] OP_XORI  = 6'd3;
    localparam logic [5:0] OP_ORI   = 6'd4;
    localparam logic [5:0] OP_ANDI  = 6'd5;
    localparam logic [5:0] OP_SLLI  = 6'd6;
    localparam logic [5:0] OP_SRLI  = 6'd7;
    localparam logic [5:0] OP_SRAI  = 6'd8;
    localparam logic [5:0] OP_LUI   = 6'd9;
    localparam logic [5:0] OP_AUIPC = 6'd10;
    localparam logic [5:0] OP_ADD   = 6'd11;
    localparam logic [5:0] OP_SUB   = 6'd12;
    localparam logic [5:0] OP_SLL   = 6'd13;
    localparam logic [5:0] OP_SLT   = 6'd14;
    localparam logic [5:0] OP_SLTU  = 6'd15;
    localparam logic [5:0] OP_XOR   = 6'd16;
    localparam logic [5:0] OP_SRL   = 6'd17;
    localparam logic [5:0] OP_SRA   = 6'd18;
    localparam logic [5:0] OP_OR    = 6'd19;
    localparam logic [5:0] OP_AND   = 6'd20;
    localparam logic [5:0] OP_JAL   = 6'd21;
    localparam logic [5:0] OP_JALR  = 6'd22;
    localparam logic [5:0] OP_BEQ   = 6'd24;
    localparam logic [5:0] OP_BNE   = 6'd25;
    localparam logic [5:0] OP_BLT   = 6'd26;
    localparam logic [5:0] OP_BGE   = 6'd27;
    localparam logic [5:0] OP_BLTU  = 6'd28;
    localparam logic [5:0] OP_BGEU  = 6'd29;
    localparam logic [5:0] OP_LB    = 6'd30;
    localparam logic [5:0] OP_LH    = 6'd31;
    localparam logic [5:0] OP_LW    = 6'd32;
    localparam logic [5:0] OP_LBU   = 6'd33;
    localparam logic [5:0] OP_LHU   = 6'd34;
    localparam logic [5:0] OP_SB    = 6'd35;
    localparam logic [5:0] OP_SH    = 6'd36;
    localparam logic [5:0] OP_SW    = 6'd37;
    localparam logic [5:0] OP_NOP   = 6'd38;
    localparam logic [5:0] OP_MUL   = 6'd39;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    logic        shamt_ok_l, shamt_ok_a;

    assign opc = if_instr_i[6:0];
    assign f3  = if_instr_i[14:12];
    assign f7  = if_instr_i[31:25];

    assign imm_i32 = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s32 = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b32 = {{20{if_instr_i[31]}}, if_instr_i[7], if_instr_i[30:25],
                      if_instr_i[11:8], 1'b0};
    assign imm_u32 = {if_instr_i[31:12], 12'b0};
    assign imm_j32 = {{12{if_instr_i[31]}}, if_instr_i[19:12], if_instr_i[20],
                      if_instr_i[30:21], 1'b0};

    // RV64 shift amounts are 6 bits, so only instr[31:26] carries the funct field.
    if (XLEN == 64) begin : g_shamt64
        assign shamt_ok_l = (if_instr_i[31:26] == 6'b000000);
        assign shamt_ok_a = (if_instr_i[31:26] == 6'b010000);
    end else begin : g_shamt32
        assign shamt_ok_l = (if_instr_i[31:25] == 7'b0000000);
        assign shamt_ok_a = (if_instr_i[31:25] == 7'b0100000);
    end

    logic [3:0]  dec_type;
    logic [5:0]  dec_op;
    logic [31:0] dec_imm32;
    logic        dec_ill, dec_jump, dec_load, dec_store;

    always_comb begin
        dec_type  = T_R;
        dec_op    = OP_NOP;
        dec_imm32 = 32'd0;
        dec_ill   = 1'b0;
        dec_jump  = 1'b0;
        dec_load  = 1'b0;
        dec_store = 1'b0;
        case (opc)
            7'b0010011: begin
                dec_type  = T_I;
                dec_imm32 = imm_i32;
                case (f3)
                    3'b000:  dec_op = OP_ADDI;
                    3'b010:  dec_op = OP_SLTI;
                    3'b011:  dec_op = OP_SLTIU;
                    3'b100:  dec_op = OP_XORI;
                    3'b110:  dec_op = OP_ORI;
                    3'b111:  dec_op = OP_ANDI;
                    3'b001:  if (shamt_ok_l) dec_op = OP_SLLI; else dec_ill = 1'b1;
                    default: begin
                        if (shamt_ok_l)      dec_op  = OP_SRLI;
                        else if (shamt_ok_a) dec_op  = OP_SRAI;
                        else                 dec_ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                dec_type  = T_U;
                dec_op    = OP_LUI;
                dec_imm32 = imm_u32;
            end
            7'b0010111: begin
                dec_type  = T_U;
                dec_op    = OP_AUIPC;
                dec_imm32 = imm_u32;
            end
            7'b0110011: begin
                dec_type = T_R;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  dec_op = OP_ADD;
                            3'b001:  dec_op = OP_SLL;
                            3'b010:  dec_op = OP_SLT;
                            3'b011:  dec_op = OP_SLTU;
                            3'b100:  dec_op = OP_XOR;
                            3'b101:  dec_op = OP_SRL;
                            3'b110:  dec_op = OP_OR;
                            default: dec_op = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec_op  = OP_SUB;
                        else if (f3 == 3'b101) dec_op  = OP_SRA;
                        else                   dec_ill = 1'b1;
                    end
                    // MUL..REMU follow funct3 order, so the op code is a plain offset.
                    7'b0000001: begin
                        if (EN_MEXT != 0) dec_op  = OP_MUL + {3'b000, f3};
                        else              dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b1101111: begin
                dec_type  = T_J;
                dec_op    = OP_JAL;
                dec_imm32 = imm_j32;
                dec_jump  = 1'b1;
            end
            7'b1100111: begin
                dec_type  = T_IJ;
                dec_op    = OP_JALR;
                dec_imm32 = imm_i32;
                dec_jump  = 1'b1;
                dec_ill   = (f3 != 3'b000);
            end
            7'b1100011: begin
                dec_type  = T_B;
                dec_imm32 = imm_b32;
                dec_jump  = 1'b1;
                case (f3)
                    3'b000:  dec_op  = OP_BEQ;
                    3'b001:  dec_op  = OP_BNE;
                    3'b100:  dec_op  = OP_BLT;
                    3'b101:  dec_op  = OP_BGE;
                    3'b110:  dec_op  = OP_BLTU;
                    3'b111:  dec_op  = OP_BGEU;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_type  = T_IL;
                dec_imm32 = imm_i32;
                dec_load  = 1'b1;
                case (f3)
                    3'b000:  dec_op  = OP_LB;
                    3'b001:  dec_op  = OP_LH;
                    3'b010:  dec_op  = OP_LW;
                    3'b100:  dec_op  = OP_LBU;
                    3'b101:  dec_op  = OP_LHU;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                dec_type  = T_S;
                dec_imm32 = imm_s32;
                dec_store = 1'b1;
                case (f3)
                    3'b000:  dec_op  = OP_SB;
                    3'b001:  dec_op  = OP_SH;
                    3'b010:  dec_op  = OP_SW;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings collapse to a flag-free NOP so issue never acts on them.
        if (dec_ill) begin
            dec_type  = T_R;
            dec_op    = OP_NOP;
            dec_imm32 = 32'd0;
            dec_jump  = 1'b0;
            dec_load  = 1'b0;
            dec_store = 1'b0;
        end
    end

    logic [XLEN-1:0] dec_imm;
    assign dec_imm = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high in that cycle; flush_i blocks both sides, and if_ready_o never depends
    // on id_ready_i (a full queue refuses input even while it is being popped).
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]   ill_cnt_q, ill_cnt_d;
    logic          push, pop;

    assign if_ready_o = (count_q < DEPTH_C);
    assign id_valid_o = (count_q != '0);
    assign push       = if_valid_i && if_ready_o && !flush_i;
    assign pop        = id_valid_o && id_ready_i && !flush_i;

    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ill_cnt_d = ill_cnt_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (push && dec_ill && (ill_cnt_q != 16'hFFFF)) ill_cnt_d = ill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ill_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    logic [3:0]      type_q  [DEPTH];
    logic [5:0]      op_q    [DEPTH];
    logic [4:0]      rs1_q   [DEPTH];
    logic [4:0]      rs2_q   [DEPTH];
    logic [4:0]      rd_q    [DEPTH];
    logic [XLEN-1:0] imm_q   [DEPTH];
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [3:0]      flags_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            type_q[wr_ptr_q]  <= dec_type;
            op_q[wr_ptr_q]    <= dec_op;
            rs1_q[wr_ptr_q]   <= if_instr_i[19:15];
            rs2_q[wr_ptr_q]   <= if_instr_i[24:20];
            rd_q[wr_ptr_q]    <= if_instr_i[11:7];
            imm_q[wr_ptr_q]   <= dec_imm;
            pc_q[wr_ptr_q]    <= if_pc_i;
            flags_q[wr_ptr_q] <= {dec_jump, dec_load, dec_store, dec_ill};
        end
    end

    assign id_type_o     = type_q[rd_ptr_q];
    assign id_op_o       = op_q[rd_ptr_q];
    assign id_rs1_o      = rs1_q[rd_ptr_q];
    assign id_rs2_o      = rs2_q[rd_ptr_q];
    assign id_rd_o       = rd_q[rd_ptr_q];
    assign id_imm_o      = imm_q[rd_ptr_q];
    assign id_pc_o       = pc_q[rd_ptr_q];
    assign id_jump_o     = flags_q[rd_ptr_q][3];
    assign id_load_o     = flags_q[rd_ptr_q][2];
    assign id_store_o    = flags_q[rd_ptr_q][1];
    assign id_illegal_o  = flags_q[rd_ptr_q][0];
    assign illegal_cnt_o = ill_cnt_q;

endmodule

// File: tb/tb_arriskv_decode_queue.sv
// Bench for arriskv_decode_queue: two instances (M-extension off and on) share
// one stimulus stream and are checked against a pattern-table reference model.
module tb_arriskv_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush_i, if_valid_i, id_ready_i;
  logic [31:0] if_instr_i;
  logic [XLEN-1:0] if_pc_i;

  logic a_if_ready, a_id_valid, a_jump, a_load, a_store, a_ill;
  logic [3:0] a_type;
  logic [5:0] a_op;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic [XLEN-1:0] a_imm, a_pc;
  logic [15:0] a_cnt;

  logic m_if_ready, m_id_valid, m_jump, m_load, m_store, m_ill;
  logic [3:0] m_type;
  logic [5:0] m_op;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [XLEN-1:0] m_imm, m_pc;
  logic [15:0] m_cnt;

  arriskv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_MEXT(0)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(a_if_ready), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_valid_o(a_id_valid), .id_ready_i(id_ready_i),
    .id_type_o(a_type), .id_op_o(a_op), .id_rs1_o(a_rs1), .id_rs2_o(a_rs2), .id_rd_o(a_rd),
    .id_imm_o(a_imm), .id_pc_o(a_pc),
    .id_jump_o(a_jump), .id_load_o(a_load), .id_store_o(a_store), .id_illegal_o(a_ill),
    .illegal_cnt_o(a_cnt)
  );

  arriskv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_MEXT(1)) dut_m (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(m_if_ready), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_valid_o(m_id_valid), .id_ready_i(id_ready_i),
    .id_type_o(m_type), .id_op_o(m_op), .id_rs1_o(m_rs1), .id_rs2_o(m_rs2), .id_rd_o(m_rd),
    .id_imm_o(m_imm), .id_pc_o(m_pc),
    .id_jump_o(m_jump), .id_load_o(m_load), .id_store_o(m_store), .id_illegal_o(m_ill),
    .illegal_cnt_o(m_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  op;
    logic [3:0]  typ;
    bit          mext;
  } pat_t;
  pat_t pats[$];

  typedef struct {
    logic [3:0]  typ;
    logic [5:0]  op;
    logic [31:0] imm;
    bit jump, load, store, illegal, use_rd, use_rs1, use_rs2;
  } dec_t;

  logic [63:0] exp_q[$];  // {pc, instr} in queue order
  int cnt_a, cnt_m;
  int total = 0;
  int bad = 0;

  task automatic add_pat(input logic [31:0] mask, input logic [31:0] match,
                         input int op, input int typ, input bit mext);
    pat_t p;
    p.mask = mask; p.match = match; p.op = 6'(op); p.typ = 4'(typ); p.mext = mext;
    pats.push_back(p);
  endtask

  task automatic fill_pats();
    logic [31:0] f3m, rm, om;
    f3m = 32'h0000707F; rm = 32'hFE00707F; om = 32'h0000007F;
    add_pat(f3m, 32'h00000013, 0, 1, 0);  add_pat(f3m, 32'h00002013, 1, 1, 0);
    add_pat(f3m, 32'h00003013, 2, 1, 0);  add_pat(f3m, 32'h00004013, 3, 1, 0);
    add_pat(f3m, 32'h00006013, 4, 1, 0);  add_pat(f3m, 32'h00007013, 5, 1, 0);
    add_pat(rm,  32'h00001013, 6, 1, 0);  add_pat(rm,  32'h00005013, 7, 1, 0);
    add_pat(rm,  32'h40005013, 8, 1, 0);
    add_pat(om,  32'h00000037, 9, 4, 0);  add_pat(om,  32'h00000017, 10, 4, 0);
    add_pat(rm,  32'h00000033, 11, 0, 0); add_pat(rm,  32'h40000033, 12, 0, 0);
    add_pat(rm,  32'h00001033, 13, 0, 0); add_pat(rm,  32'h00002033, 14, 0, 0);
    add_pat(rm,  32'h00003033, 15, 0, 0); add_pat(rm,  32'h00004033, 16, 0, 0);
    add_pat(rm,  32'h00005033, 17, 0, 0); add_pat(rm,  32'h40005033, 18, 0, 0);
    add_pat(rm,  32'h00006033, 19, 0, 0); add_pat(rm,  32'h00007033, 20, 0, 0);
    add_pat(om,  32'h0000006F, 21, 5, 0); add_pat(f3m, 32'h00000067, 22, 6, 0);
    add_pat(f3m, 32'h00000063, 24, 3, 0); add_pat(f3m, 32'h00001063, 25, 3, 0);
    add_pat(f3m, 32'h00004063, 26, 3, 0); add_pat(f3m, 32'h00005063, 27, 3, 0);
    add_pat(f3m, 32'h00006063, 28, 3, 0); add_pat(f3m, 32'h00007063, 29, 3, 0);
    add_pat(f3m, 32'h00000003, 30, 7, 0); add_pat(f3m, 32'h00001003, 31, 7, 0);
    add_pat(f3m, 32'h00002003, 32, 7, 0); add_pat(f3m, 32'h00004003, 33, 7, 0);
    add_pat(f3m, 32'h00005003, 34, 7, 0);
    add_pat(f3m, 32'h00000023, 35, 2, 0); add_pat(f3m, 32'h00001023, 36, 2, 0);
    add_pat(f3m, 32'h00002023, 37, 2, 0);
    for (int k = 0; k < 8; k++) add_pat(rm, 32'h02000033 | (k << 12), 39 + k, 0, 1);
  endtask

  function automatic dec_t ref_decode(input logic [31:0] i, input bit en_m);
    dec_t d;
    d = '{default: 0};
    d.op = 6'd38;
    d.illegal = 1;
    foreach (pats[k])
      if (((i & pats[k].mask) == pats[k].match) && (!pats[k].mext || en_m)) begin
        d.illegal = 0; d.op = pats[k].op; d.typ = pats[k].typ;
      end
    if (!d.illegal) begin
      case (d.typ)
        4'd0: begin d.imm = 0; d.use_rd = 1; d.use_rs1 = 1; d.use_rs2 = 1; end
        4'd1, 4'd6, 4'd7: begin d.imm = {{20{i[31]}}, i[31:20]}; d.use_rd = 1; d.use_rs1 = 1; end
        4'd2: begin d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; d.use_rs1 = 1; d.use_rs2 = 1; end
        4'd3: begin d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; d.use_rs1 = 1; d.use_rs2 = 1; end
        4'd4: begin d.imm = {i[31:12], 12'h000}; d.use_rd = 1; end
        default: begin d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; d.use_rd = 1; end
      endcase
      d.jump  = (d.typ == 4'd3) || (d.typ == 4'd5) || (d.typ == 4'd6);
      d.load  = (d.typ == 4'd7);
      d.store = (d.typ == 4'd2);
    end
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_side(input string tag, input bit en_m, input logic ready, input logic valid,
                            input logic [3:0] typ, input logic [5:0] op,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] imm, input logic [31:0] pc,
                            input logic jump, input logic load, input logic store, input logic ill,
                            input logic [15:0] cnt);
    dec_t d;
    logic [31:0] ins;
    chk({tag, ".id_valid"}, valid, exp_q.size() != 0);
    chk({tag, ".if_ready"}, ready, exp_q.size() < DEPTH);
    chk({tag, ".ill_cnt"}, cnt, en_m ? cnt_m : cnt_a);
    if (exp_q.size() != 0) begin
      ins = exp_q[0][31:0];
      d = ref_decode(ins, en_m);
      chk({tag, ".pc"}, pc, exp_q[0][63:32]);
      chk({tag, ".illegal"}, ill, d.illegal);
      chk({tag, ".op"}, op, d.op);
      chk({tag, ".jump"}, jump, d.jump);
      chk({tag, ".load"}, load, d.load);
      chk({tag, ".store"}, store, d.store);
      if (!d.illegal) begin
        chk({tag, ".type"}, typ, d.typ);
        chk({tag, ".imm"}, imm, d.imm);
        if (d.use_rd)  chk({tag, ".rd"}, rd, ins[11:7]);
        if (d.use_rs1) chk({tag, ".rs1"}, rs1, ins[19:15]);
        if (d.use_rs2) chk({tag, ".rs2"}, rs2, ins[24:20]);
      end
    end
  endtask

  // Advance the model with the inputs now applied, cross the clock edge, then
  // compare both instances against the model on the falling edge.
  task automatic tick();
    bit push, pop;
    if (rst) begin
      exp_q.delete(); cnt_a = 0; cnt_m = 0;
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      push = if_valid_i && (exp_q.size() < DEPTH);
      pop  = id_ready_i && (exp_q.size() != 0);
      if (push) begin
        if (ref_decode(if_instr_i, 0).illegal && cnt_a < 16'hFFFF) cnt_a++;
        if (ref_decode(if_instr_i, 1).illegal && cnt_m < 16'hFFFF) cnt_m++;
      end
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({if_pc_i, if_instr_i});
    end
    @(negedge clk);
    check_side("a", 0, a_if_ready, a_id_valid, a_type, a_op, a_rs1, a_rs2, a_rd, a_imm, a_pc,
               a_jump, a_load, a_store, a_ill, a_cnt);
    check_side("m", 1, m_if_ready, m_id_valid, m_type, m_op, m_rs1, m_rs2, m_rd, m_imm, m_pc,
               m_jump, m_load, m_store, m_ill, m_cnt);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic rdy);
    if_valid_i = v; if_instr_i = instr; id_ready_i = rdy; if_pc_i = $urandom();
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    int k;
    logic [31:0] r;
    logic [31:0] specials[6];
    specials = '{32'h0FF0000F, 32'h00000073, 32'h02001013, 32'h42005013, 32'h00001067, 32'h00500092};
    sel = $urandom_range(0, 9);
    r = $urandom();
    if (sel == 0) return r;
    if (sel == 1) return specials[$urandom_range(0, 5)];
    k = $urandom_range(0, pats.size() - 1);
    return (pats[k].match & pats[k].mask) | (r & ~pats[k].mask);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [3:0]  typ;
    logic [5:0]  op;
    logic [31:0] imm;
    logic        jump, load, store, ill;
    logic [5:0]  op_m;
    logic        ill_m;
  } vec_t;
  vec_t vecs[15];

  int exp_ca, exp_cm;

  initial begin
    vecs[0]  = '{32'h00500093, 4'd1, 6'd0,  32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0};
    vecs[1]  = '{32'hFE000EE3, 4'd3, 6'd24, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 1'b0, 6'd24, 1'b0};
    vecs[2]  = '{32'h02208133, 4'd0, 6'd38, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd39, 1'b0};
    vecs[3]  = '{32'h000122B7, 4'd4, 6'd9,  32'h00012000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd9,  1'b0};
    vecs[4]  = '{32'hFFC12083, 4'd7, 6'd32, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 1'b0, 6'd32, 1'b0};
    vecs[5]  = '{32'h00112623, 4'd2, 6'd37, 32'h0000000C, 1'b0, 1'b0, 1'b1, 1'b0, 6'd37, 1'b0};
    vecs[6]  = '{32'h40515093, 4'd1, 6'd8,  32'h00000405, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8,  1'b0};
    vecs[7]  = '{32'h42515093, 4'd0, 6'd38, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd38, 1'b1};
    vecs[8]  = '{32'h008000EF, 4'd5, 6'd21, 32'h00000008, 1'b1, 1'b0, 1'b0, 1'b0, 6'd21, 1'b0};
    vecs[9]  = '{32'h0000000F, 4'd0, 6'd38, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd38, 1'b1};
    vecs[10] = '{32'h00500092, 4'd0, 6'd38, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd38, 1'b1};
    vecs[11] = '{32'h40208133, 4'd0, 6'd12, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd12, 1'b0};
    vecs[12] = '{32'h00008067, 4'd6, 6'd22, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 6'd22, 1'b0};
    vecs[13] = '{32'hFFF13093, 4'd1, 6'd2,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2,  1'b0};
    vecs[14] = '{32'h0220B133, 4'd0, 6'd38, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd42, 1'b0};

    fill_pats();
    cnt_a = 0; cnt_m = 0;
    rst = 1'b1; flush_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk("reset.id_valid", a_id_valid, 1'b0);
    chk("reset.if_ready", a_if_ready, 1'b1);
    chk("reset.ill_cnt", a_cnt, 16'd0);
    rst = 1'b0;

    // Table: push one instruction, check the head next cycle, then it pops.
    exp_ca = 0; exp_cm = 0;
    for (int v = 0; v < 15; v++) begin
      drive(1'b1, vecs[v].instr, 1'b1);
      tick();
      if (vecs[v].ill) exp_ca++;
      if (vecs[v].ill_m) exp_cm++;
      chk($sformatf("vec%0d.valid", v), a_id_valid, 1'b1);
      chk($sformatf("vec%0d.op", v), a_op, vecs[v].op);
      chk($sformatf("vec%0d.illegal", v), a_ill, vecs[v].ill);
      chk($sformatf("vec%0d.jls", v), {a_jump, a_load, a_store}, {vecs[v].jump, vecs[v].load, vecs[v].store});
      if (!vecs[v].ill) begin
        chk($sformatf("vec%0d.type", v), a_type, vecs[v].typ);
        chk($sformatf("vec%0d.imm", v), a_imm, vecs[v].imm);
      end
      chk($sformatf("vec%0d.op_m", v), m_op, vecs[v].op_m);
      chk($sformatf("vec%0d.illegal_m", v), m_ill, vecs[v].ill_m);
      chk($sformatf("vec%0d.cnt", v), a_cnt, exp_ca);
      chk($sformatf("vec%0d.cnt_m", v), m_cnt, exp_cm);
      drive(1'b0, 32'h0, 1'b1);
      tick();
      chk($sformatf("vec%0d.popped", v), a_id_valid, 1'b0);
    end

    // Fill to DEPTH with the issue side stalled; extra input must be refused.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 32'h00000093 | ((k + 1) << 20), 1'b0);
      tick();
    end
    chk("full.if_ready", a_if_ready, 1'b0);
    drive(1'b1, 32'h06300093, 1'b0);
    tick();
    chk("full.ignored_head", a_imm, 32'd1);
    // Full with a pop: the pop happens, the offered input is not taken.
    drive(1'b1, 32'h06300093, 1'b1);
    tick();
    chk("fullpop.if_ready", a_if_ready, 1'b1);
    chk("fullpop.head", a_imm, 32'd2);
    for (int k = 2; k <= DEPTH; k++) begin
      chk($sformatf("drain.order%0d", k), a_imm, k);
      drive(1'b0, 32'h0, 1'b1);
      tick();
    end
    chk("drain.empty", a_id_valid, 1'b0);

    // Three queued, then flush with a valid input present.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hFFFFFFFF, 1'b0);
      tick();
    end
    flush_i = 1'b1;
    drive(1'b1, 32'h00700093, 1'b1);
    tick();
    flush_i = 1'b0;
    chk("flush.id_valid", a_id_valid, 1'b0);
    chk("flush.cnt_kept", a_cnt, exp_ca + 3);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("flush.input_absent", a_id_valid, 1'b0);

    // Reset in the middle of traffic.
    drive(1'b1, 32'hFFFFFFFF, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h00500093, 1'b1);
    tick();
    rst = 1'b0;
    chk("midrst.id_valid", a_id_valid, 1'b0);
    chk("midrst.ill_cnt", a_cnt, 16'd0);
    chk("midrst.ill_cnt_m", m_cnt, 16'd0);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      flush_i = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
